// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared constants for the unified-memory access controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    localparam int c_AW_DEFAULT = 8;
    localparam int c_DW_DEFAULT = 8;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_RESP   = 2'd2;

    // Grant/owner code doubles as the bit index into the request vector.
    localparam logic c_GNT_FETCH = 1'b0;
    localparam logic c_GNT_DATA  = 1'b1;

    function automatic logic rr_pick(input logic [1:0] req, input logic last_grant);
        logic winner;
        if (req == 2'b11) begin
            winner = ~last_grant;
        end else if (req[c_GNT_DATA]) begin
            winner = c_GNT_DATA;
        end else begin
            winner = c_GNT_FETCH;
        end
        return winner;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-input round-robin arbiter; last grant updates on accept.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import mem_access_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic r_last_grant;
    logic w_winner;

    always_comb begin
        w_winner = rr_pick(req, r_last_grant);
        grant    = 2'b00;
        if (req != 2'b00) begin
            grant = (w_winner == c_GNT_DATA) ? 2'b10 : 2'b01;
        end
    end

    // Reset to FETCH so the data side wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= c_GNT_FETCH;
        end else if (accept && (req != 2'b00)) begin
            r_last_grant <= w_winner;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Arbitrated fetch/data initiator for a single-port 8-bit memory.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int AW = c_AW_DEFAULT,
    parameter int DW = c_DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_valid,
    input  logic [AW-1:0] f_addr,
    output logic          f_ready,
    output logic          f_rsp_valid,
    output logic [DW-1:0] f_rsp_data,
    input  logic          d_valid,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic          d_rsp_valid,
    output logic [DW-1:0] d_rsp_data,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dout
);

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [1:0]    w_grant;
    logic          w_accept;
    logic          w_take_data;

    logic          r_owner;
    logic          r_is_store;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_din;
    logic          r_mem_we;
    logic          r_f_rsp_valid;
    logic [DW-1:0] r_f_rsp_data;
    logic          r_d_rsp_valid;
    logic [DW-1:0] r_d_rsp_data;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({d_valid, f_valid}),
        .accept (w_accept),
        .grant  (w_grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        f_ready      = 1'b0;
        d_ready      = 1'b0;
        w_accept     = 1'b0;
        w_take_data  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                f_ready     = w_grant[c_GNT_FETCH];
                d_ready     = w_grant[c_GNT_DATA];
                w_take_data = d_valid & w_grant[c_GNT_DATA];
                w_accept    = (f_valid & w_grant[c_GNT_FETCH]) | w_take_data;
                if (w_accept) begin
                    w_state_next = c_ST_ACCESS;
                end
            end
            c_ST_ACCESS: w_state_next = c_ST_RESP;
            c_ST_RESP:   w_state_next = c_ST_IDLE;
            default:     w_state_next = c_ST_IDLE;
        endcase
    end

    // Response pulses are set at the edge ending ACCESS, so they live for the RESP cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner       <= c_GNT_FETCH;
            r_is_store    <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_din     <= '0;
            r_mem_we      <= 1'b0;
            r_f_rsp_valid <= 1'b0;
            r_f_rsp_data  <= '0;
            r_d_rsp_valid <= 1'b0;
            r_d_rsp_data  <= '0;
        end else begin
            r_f_rsp_valid <= 1'b0;
            r_d_rsp_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_mem_addr <= w_take_data ? d_addr : f_addr;
                        r_mem_din  <= (w_take_data && d_we) ? d_wdata : '0;
                        r_mem_we   <= w_take_data & d_we;
                        r_owner    <= w_take_data ? c_GNT_DATA : c_GNT_FETCH;
                        r_is_store <= w_take_data & d_we;
                    end
                end
                c_ST_ACCESS: begin
                    r_mem_we <= 1'b0;
                    if (r_owner == c_GNT_DATA) begin
                        r_d_rsp_valid <= 1'b1;
                        r_d_rsp_data  <= r_is_store ? '0 : mem_dout;
                    end else begin
                        r_f_rsp_valid <= 1'b1;
                        r_f_rsp_data  <= mem_dout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr    = r_mem_addr;
    assign mem_din     = r_mem_din;
    assign mem_we      = r_mem_we;
    assign f_rsp_valid = r_f_rsp_valid;
    assign f_rsp_data  = r_f_rsp_data;
    assign d_rsp_valid = r_d_rsp_valid;
    assign d_rsp_data  = r_d_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Self-checking bench for mem_access_ctrl with a memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       f_valid, d_valid, d_we;
    logic [7:0] f_addr, d_addr, d_wdata;
    logic       f_ready, d_ready, f_rsp_valid, d_rsp_valid, mem_we;
    logic [7:0] f_rsp_data, d_rsp_data, mem_addr, mem_din, mem_dout;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    bit         chk_en = 1'b0;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.AW(8), .DW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .f_valid     (f_valid),
        .f_addr      (f_addr),
        .f_ready     (f_ready),
        .f_rsp_valid (f_rsp_valid),
        .f_rsp_data  (f_rsp_data),
        .d_valid     (d_valid),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_ready     (d_ready),
        .d_rsp_valid (d_rsp_valid),
        .d_rsp_data  (d_rsp_data),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_we      (mem_we),
        .mem_dout    (mem_dout)
    );

    // Memory: write on posedge regardless of rst, combinational read.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 19 + 33);
        forever begin
            @(posedge clk);
            if (mem_we) mem[mem_addr] <= mem_din;
        end
    end
    assign mem_dout = mem[mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: an accept at cycle N owns the memory at N+1 and responds at N+2.
    initial begin
        bit         m_have = 1'b0;
        int         m_tacc = 0;
        int         t      = 0;
        bit         m_own_d = 1'b0, m_store = 1'b0, m_last_d = 1'b0;
        logic [7:0] m_addr = 8'h00, m_din = 8'h00, m_fdata = 8'h00, m_ddata = 8'h00;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 19 + 33);
        forever begin
            @(negedge clk);
            if (chk_en) begin
                int age;
                bit idle, wd, wf;
                age  = t - m_tacc;
                idle = !(m_have && age >= 1 && age <= 2);
                wd   = idle && d_valid && (!f_valid || !m_last_d);
                wf   = idle && f_valid && (!d_valid || m_last_d);
                check("m_f_ready", f_ready, wf);
                check("m_d_ready", d_ready, wd);
                check("m_mem_we", mem_we, m_have && age == 1 && m_store);
                check("m_mem_addr", mem_addr, m_addr);
                check("m_mem_din", mem_din, m_din);
                check("m_f_rsp_valid", f_rsp_valid, m_have && age == 2 && !m_own_d);
                check("m_d_rsp_valid", d_rsp_valid, m_have && age == 2 && m_own_d);
                check("m_f_rsp_data", f_rsp_data, m_fdata);
                check("m_d_rsp_data", d_rsp_data, m_ddata);
                if (m_have && age == 1) begin
                    if (m_store) begin
                        ref_mem[m_addr] = m_din;
                        m_ddata = 8'h00;
                    end else if (m_own_d) begin
                        m_ddata = ref_mem[m_addr];
                    end else begin
                        m_fdata = ref_mem[m_addr];
                    end
                end
                if (!rst && (wd || wf)) begin
                    m_have   = 1'b1;
                    m_tacc   = t;
                    m_own_d  = wd;
                    m_store  = wd && d_we;
                    m_addr   = wd ? d_addr : f_addr;
                    m_din    = (wd && d_we) ? d_wdata : 8'h00;
                    m_last_d = wd;
                end
                if (rst) begin
                    m_have   = 1'b0;
                    m_addr   = 8'h00;
                    m_din    = 8'h00;
                    m_fdata  = 8'h00;
                    m_ddata  = 8'h00;
                    m_last_d = 1'b0;
                end
                t++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; f_valid = 1'b0; d_valid = 1'b0; d_we = 1'b0;
        f_addr = 8'h00; d_addr = 8'h00; d_wdata = 8'h00;
        @(posedge clk);
        #1 chk_en = 1'b1;
        tick();
        rst = 1'b0;

        // Reset state and idle
        @(negedge clk);
        check("rst_f_ready", f_ready, 1'b0);
        check("rst_d_ready", d_ready, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_f_rsp_valid", f_rsp_valid, 1'b0);
        check("rst_d_rsp_data", d_rsp_data, 8'h00);
        tick(); tick();

        // Fetch from 0x00
        f_valid = 1'b1; f_addr = 8'h00;
        @(negedge clk); check("fetch_ready", f_ready, 1'b1);
        tick(); f_valid = 1'b0;
        @(negedge clk); check("fetch_mem_addr", mem_addr, 8'h00);
        check("fetch_mem_we", mem_we, 1'b0);
        tick();
        @(negedge clk); check("fetch_rsp_valid", f_rsp_valid, 1'b1);
        check("fetch_rsp_data", f_rsp_data, 8'h21);
        tick();

        // Store 0xAA to 0xFB, then load it back
        d_valid = 1'b1; d_we = 1'b1; d_addr = 8'hFB; d_wdata = 8'hAA;
        @(negedge clk); check("st_ready", d_ready, 1'b1);
        check("st_we_early", mem_we, 1'b0);
        tick(); d_valid = 1'b0; d_we = 1'b0;
        @(negedge clk); check("st_we", mem_we, 1'b1);
        check("st_din", mem_din, 8'hAA);
        tick();
        @(negedge clk); check("st_rsp_valid", d_rsp_valid, 1'b1);
        check("st_rsp_data", d_rsp_data, 8'h00);
        check("st_we_late", mem_we, 1'b0);
        tick();
        d_valid = 1'b1; d_addr = 8'hFB;
        @(negedge clk); check("ld_ready", d_ready, 1'b1);
        tick(); d_valid = 1'b0;
        tick();
        @(negedge clk); check("ld_rsp_valid", d_rsp_valid, 1'b1);
        check("ld_rsp_data", d_rsp_data, 8'hAA);
        tick();

        // Contention from a fresh reset: D, F, D, F
        rst = 1'b1;
        tick();
        rst = 1'b0; f_valid = 1'b1; d_valid = 1'b1; f_addr = 8'h01; d_addr = 8'h02;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("cont_d_ready", d_ready, (k % 2) == 0);
            check("cont_f_ready", f_ready, (k % 2) == 1);
            tick();
            @(negedge clk);
            check("cont_busy_ready", {f_ready, d_ready}, 2'b00);
            tick();
            @(negedge clk);
            if ((k % 2) == 0) begin
                check("cont_d_rsp", {d_rsp_valid, f_rsp_valid, d_rsp_data}, {2'b10, 8'h47});
            end else begin
                check("cont_f_rsp", {f_rsp_valid, d_rsp_valid, f_rsp_data}, {2'b10, 8'h34});
            end
            tick();
        end
        f_valid = 1'b0; d_valid = 1'b0;

        // Reset during the ACCESS cycle of a store
        d_valid = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_wdata = 8'h5C;
        @(negedge clk); check("rs_ready", d_ready, 1'b1);
        tick(); d_valid = 1'b0; d_we = 1'b0; rst = 1'b1;
        @(negedge clk); check("rs_we", mem_we, 1'b1);
        tick(); rst = 1'b0; f_valid = 1'b1; f_addr = 8'h03;
        @(negedge clk); check("rs_no_rsp", d_rsp_valid, 1'b0);
        check("rs_idle_ready", f_ready, 1'b1);
        check("rs_mem_commit", mem[8'h10], 8'h5C);
        tick(); f_valid = 1'b0;
        tick(); tick();

        // Fetch request presented only during ACCESS of a load
        d_valid = 1'b1; d_addr = 8'h20;
        @(negedge clk); check("oi_d_ready", d_ready, 1'b1);
        tick(); d_valid = 1'b0; f_valid = 1'b1; f_addr = 8'h05;
        @(negedge clk); check("oi_f_ready", f_ready, 1'b0);
        tick(); f_valid = 1'b0;
        @(negedge clk); check("oi_d_rsp", {d_rsp_valid, f_rsp_valid, d_rsp_data}, {2'b10, 8'h81});
        tick();
        @(negedge clk); check("oi_no_f_rsp", f_rsp_valid, 1'b0);
        tick(); tick();
        @(negedge clk); check("oi_no_f_rsp_late", f_rsp_valid, 1'b0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Bus initiator that drives the single-port 8-bit unified memory: it produces addr/din/we and consumes the combinational dout.
- Serves two requesters: instruction fetch (read-only) and the data path (load/store).
- Arbitrates between them round-robin, sequences each access through a 3-state FSM, and returns a one-cycle response pulse.
- Sits between the CPU control unit and the memory.

Parameters:
- AW, 8, address width (memory depth 2**AW).
- DW, 8, data width.

Ports:
- clk  input  1  system clock; memory write occurs on posedge.
- rst  input  1  synchronous active-high reset.
- f_valid  input  1  fetch request.
- f_addr  input  AW  fetch address.
- f_ready  output  1  fetch request accepted this cycle.
- f_rsp_valid  output  1  fetch data valid (one-cycle pulse).
- f_rsp_data  output  DW  fetched byte.
- d_valid  input  1  data request.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  AW  data address.
- d_wdata  input  DW  store data.
- d_ready  output  1  data request accepted this cycle.
- d_rsp_valid  output  1  load data or store acknowledge (one-cycle pulse).
- d_rsp_data  output  DW  loaded byte; 0 for stores.
- mem_addr  output  AW  to memory addr (registered).
- mem_din  output  DW  to memory din (registered).
- mem_we  output  1  to memory we (registered).
- mem_dout  input  DW  from memory dout (combinational read).

Behaviour:
- Reset values:
  - state = IDLE; mem_addr, mem_din, mem_we = 0.
  - f/d_rsp_valid = 0; f/d_rsp_data = 0.
  - last_grant = FETCH, so data wins the first contention.
- Ready outputs are combinational and asserted only in IDLE:
  - f_ready = IDLE & grant_f; d_ready = IDLE & grant_d.
  - At most one is high. A request transfers when valid & ready.
- Arbitration (IDLE only):
  - Only one valid: it wins.
  - Both valid: winner is the one not in last_grant.
  - last_grant updates on every accept.
- FSM:
  - IDLE → ACCESS on accept. Registers:
    - mem_addr ← winner addr.
    - mem_din ← d_wdata for a data store, else 0.
    - mem_we ← d_we for data, 0 for fetch.
    - owner ← winner; is_store ← d_we for data, else 0.
  - ACCESS → RESP:
    - Memory sees mem_addr and mem_we for the whole cycle; a store commits at the edge ending ACCESS.
    - For a read, capture mem_dout into the owner's rsp_data at that edge.
    - For a store, set d_rsp_data ← 0.
    - mem_we ← 0 at that edge.
  - RESP → IDLE:
    - Owner's rsp_valid is high for exactly this cycle; the other rsp_valid stays 0.
    - rsp_data holds until overwritten by a later access to the same port.
- Latency and throughput:
  - Accept at cycle N, memory access at N+1, rsp_valid at N+2.
  - Next accept no earlier than N+3; peak throughput is 1 access per 3 cycles.
- No response backpressure: requesters must sample on rsp_valid.
- Ignored inputs:
  - Requests presented outside IDLE are not accepted and need not be held stable.
  - Requester inputs are sampled only on the accept cycle.
- Load after store to the same address:
  - Serialized by the FSM.
  - The load returns the new value, since the store committed before the load's ACCESS cycle.
- mem_addr holds its last value between accesses. Only mem_we must be 0 outside ACCESS.
- Reset mid-operation:
  - rst in ACCESS with mem_we = 1: the store at that edge still commits, because the memory samples we before the reset clears it.
  - All pending responses are dropped; no rsp_valid is issued afterward.
  - rst in RESP suppresses nothing already pulsed that cycle; the next cycle is IDLE.
- Address arithmetic: none. Addresses pass through unmodified; wrap-around is the requester's concern.

Decomposition:
- Package mem_access_pkg:
  - State encoding IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2.
  - Grant/owner encoding GNT_FETCH = 1'b0, GNT_DATA = 1'b1.
  - Default AW/DW constants.
- One sub-module, rr_arb2:
  - 2-input round-robin arbiter with last_grant register, clk/rst, req[1:0], accept, grant[1:0].
  - FSM, datapath registers and response logic stay in mem_access_ctrl.

Test Plan:
- Reset then idle: rst for 2 cycles → all outputs 0, f_ready = d_ready = 0 with no valids, mem_we never asserted.
- Fetch: f_valid = 1, f_addr = 8'h00 (memory holds 8'b0010_0001) → f_ready at N, mem_addr = 8'h00 at N+1, f_rsp_valid pulse at N+2 with f_rsp_data = 8'h21.
- Store then load: d_we = 1, d_addr = 8'hFB, d_wdata = 8'hAA → mem_we high only at N+1, d_rsp_valid at N+2 with data 0. Then a load from 8'hFB → d_rsp_data = 8'hAA.
- Contention: f_valid and d_valid held high from reset with f_addr = 8'h01, d_addr = 8'h02 → grants D, F, D, F on accept cycles 3 apart; responses routed to the correct port only.
- Reset mid-store: d_we = 1, d_addr = 8'h10, d_wdata = 8'h5C, rst asserted in the ACCESS cycle → no d_rsp_valid, state IDLE next cycle, mem[8'h10] = 8'h5C.
- Request outside IDLE: f_valid pulsed only during ACCESS of a data load → not accepted, no f_rsp_valid.
